// File: rtl/ysyx_040066_id_queue.sv
//------------------------------------------------------------------------------
// ysyx_040066_id_queue : decode front end (instruction queue + decode slot)
// Optional direct IF->slot path: define YSYX_040066_ID_QUEUE_BYPASS_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_040066_id_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    input  logic                   in_err,
    input  logic                   rs1_valid,
    input  logic                   rs2_valid,
    input  logic                   out_block,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [31:0]            out_instr,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   out_rd_we,
    output logic                   out_illegal,
    output logic                   out_ifault,
    output logic                   rs_block,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
    localparam logic [6:0] c_OPC_OP        = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;

    // Queue storage; only written on push, so no reset is needed.
    logic [PC_W-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];
    logic            fifo_err_q   [DEPTH];

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            slot_valid_q, slot_valid_d;
    logic [PC_W-1:0] slot_pc_q, slot_pc_d;
    logic [31:0]     slot_instr_q, slot_instr_d;
    logic            slot_err_q, slot_err_d;

    logic       w_fire, w_slot_free, w_enq, w_bypass, w_deq, w_push, w_slot_live;
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_ill_raw, w_uses_rs1, w_uses_rs2, w_wr_raw;

    assign in_ready    = !rst && !flush && (count_q < c_DEPTH);
    assign count       = count_q;
    assign w_slot_live = slot_valid_q && !rst;
    assign w_opc       = slot_instr_q[6:0];
    assign w_f3        = slot_instr_q[14:12];

    always_comb begin
        w_ill_raw  = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_wr_raw   = 1'b1;
        case (w_opc)
            c_OPC_LOAD: begin
                w_uses_rs1 = 1'b1;
                w_ill_raw  = (w_f3 == 3'b111);
            end
            c_OPC_MISC_MEM: begin
                w_ill_raw = (slot_instr_q != 32'h0000_100f);
                w_wr_raw  = 1'b0;
            end
            c_OPC_OP_IMM, c_OPC_OP_IMM_32: w_uses_rs1 = 1'b1;
            c_OPC_AUIPC, c_OPC_LUI, c_OPC_JAL: ;
            c_OPC_STORE: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_ill_raw  = w_f3[2];
                w_wr_raw   = 1'b0;
            end
            c_OPC_OP, c_OPC_OP_32: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_ill_raw  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                w_wr_raw   = 1'b0;
            end
            c_OPC_JALR: begin
                w_uses_rs1 = 1'b1;
                w_ill_raw  = (w_f3 != 3'b000);
            end
            c_OPC_SYSTEM: begin
                w_uses_rs1 = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b011);
                if (w_f3 == 3'b000) begin
                    w_wr_raw  = 1'b0;
                    w_ill_raw = !((slot_instr_q == 32'h0000_0073) ||
                                  (slot_instr_q == 32'h0010_0073) ||
                                  (slot_instr_q == 32'h3020_0073));
                end else if (w_f3 == 3'b100) begin
                    w_ill_raw = 1'b1;
                end
            end
            default: w_ill_raw = 1'b1;
        endcase
    end

    // A fetch-faulted entry carries no meaningful operands, so it never hazards.
    assign out_ifault  = w_slot_live && slot_err_q;
    assign out_illegal = w_slot_live && !slot_err_q && w_ill_raw;
    assign out_rd_we   = w_slot_live && !slot_err_q && !w_ill_raw && w_wr_raw
                         && (slot_instr_q[11:7] != 5'd0);
    assign rs_block    = w_slot_live && !flush && !slot_err_q &&
                         ((w_uses_rs1 && !rs1_valid) || (w_uses_rs2 && !rs2_valid));
    assign out_valid   = w_slot_live && !rs_block && !flush;
    assign out_pc      = slot_pc_q;
    assign out_instr   = slot_instr_q;
    assign out_rs1     = slot_instr_q[19:15];
    assign out_rs2     = slot_instr_q[24:20];
    assign out_rd      = slot_instr_q[11:7];

    always_comb begin
        w_fire      = out_valid && !out_block;
        w_slot_free = !slot_valid_q || w_fire;
        w_enq       = in_valid && in_ready;
`ifdef YSYX_040066_ID_QUEUE_BYPASS_EN
        w_bypass    = w_enq && (count_q == '0) && w_slot_free;
`else
        w_bypass    = 1'b0;
`endif
        w_deq       = w_slot_free && (count_q != '0) && !flush;
        w_push      = w_enq && !w_bypass;

        rd_ptr_d     = w_deq  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d     = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d      = count_q;
        if (w_push && !w_deq)
            count_d = count_q + CW'(1);
        else if (!w_push && w_deq)
            count_d = count_q - CW'(1);

        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        slot_err_d   = slot_err_q;
        if (w_deq) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = fifo_pc_q[rd_ptr_q];
            slot_instr_d = fifo_instr_q[rd_ptr_q];
            slot_err_d   = fifo_err_q[rd_ptr_q];
        end else if (w_bypass) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = in_pc;
            slot_instr_d = in_instr;
            slot_err_d   = in_err;
        end else if (w_fire) begin
            slot_valid_d = 1'b0;
        end

        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= '0;
            slot_err_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            slot_err_q   <= slot_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_pc_q[wr_ptr_q]    <= in_pc;
            fifo_instr_q[wr_ptr_q] <= in_instr;
            fifo_err_q[wr_ptr_q]   <= in_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_040066_id_queue.sv
//------------------------------------------------------------------------------
// tb_ysyx_040066_id_queue : directed bench for the decode front end
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_040066_id_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, in_err;
    logic [PC_W-1:0]  in_pc, out_pc;
    logic [31:0]      in_instr, out_instr;
    logic             rs1_valid, rs2_valid, out_block, out_valid;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic             out_rd_we, out_illegal, out_ifault, rs_block;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_040066_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_err(in_err),
        .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .out_block(out_block),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_ifault(out_ifault),
        .rs_block(rs_block), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enqueue one instruction, wait (bounded) for it to be issuable, capture flags, let it fire.
    task automatic issue(input logic [63:0] pc, input logic [31:0] ins, input logic err,
                         output logic ill, output logic flt, output logic we, output logic ok);
        in_valid = 1'b1; in_pc = pc; in_instr = ins; in_err = err;
        tick();
        in_valid = 1'b0; in_err = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else tick();
        end
        ill = out_illegal; flt = out_ifault; we = out_rd_we;
        tick();
    endtask

    logic ill, flt, we, ok, seen;
    int   sent, recv;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_err = 1'b0;
        rs1_valid = 1'b1; rs2_valid = 1'b1; out_block = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_count", 64'(count), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_rs_block", 64'(rs_block), 0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", 64'(in_ready), 1);

        // Single addi x1,x0,5
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'h0050_0093;
        tick();
        in_valid = 1'b0;
`ifndef YSYX_040066_ID_QUEUE_BYPASS_EN
        chk("addi_n1_valid", 64'(out_valid), 0);
        chk("addi_n1_count", 64'(count), 1);
        tick();
`endif
        chk("addi_valid", 64'(out_valid), 1);
        chk("addi_pc", out_pc, 64'h8000_0000);
        chk("addi_rd", 64'(out_rd), 1);
        chk("addi_rd_we", 64'(out_rd_we), 1);
        chk("addi_illegal", 64'(out_illegal), 0);
        chk("addi_count", 64'(count), 0);
        tick();
        chk("addi_gone", 64'(out_valid), 0);

        // Fill slot + queue under out_block, then drain in order
        out_block = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1; in_pc = 64'h1000 + 64'(4 * i);
            in_instr = {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
            #1;
            chk("fill_ready", 64'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", 64'(count), DEPTH);
        chk("full_in_ready", 64'(in_ready), 0);
        chk("full_head_pc", out_pc, 64'h1000);
        out_block = 1'b0; #1;
        chk("full_deq_in_ready", 64'(in_ready), 0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            chk("drain_valid", 64'(out_valid), 1);
            chk("drain_pc", out_pc, 64'h1000 + 64'(4 * k));
            chk("drain_rd", 64'(out_rd), 64'(k + 1));
            tick();
        end
        chk("drain_empty_valid", 64'(out_valid), 0);
        chk("drain_empty_count", 64'(count), 0);

        // Operand hazard on rs2
        rs2_valid = 1'b0;
        in_valid = 1'b1; in_pc = 64'h2000; in_instr = 32'h0020_81b3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6 && !rs_block; i++) tick();
        for (int k = 0; k < 3; k++) begin
            chk("haz_rs_block", 64'(rs_block), 1);
            chk("haz_out_valid", 64'(out_valid), 0);
            chk("haz_pc", out_pc, 64'h2000);
            chk("haz_rd", 64'(out_rd), 3);
            tick();
        end
        rs2_valid = 1'b1; #1;
        chk("haz_release_valid", 64'(out_valid), 1);
        tick();
        chk("haz_fired", 64'(out_valid), 0);

        // Flush with 3 queued + slot, input offered during flush
        out_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 64'h3000 + 64'(4 * i); in_instr = 32'h0000_0013;
            tick();
        end
        chk("preflush_count", 64'(count), 3);
        chk("preflush_valid", 64'(out_valid), 1);
        in_pc = 64'h3ff0; flush = 1'b1; #1;
        chk("flush_in_ready", 64'(in_ready), 0);
        chk("flush_out_valid", 64'(out_valid), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_block = 1'b0;
        chk("postflush_count", 64'(count), 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("postflush_nothing_issued", 64'(seen), 0);

        // Decode flags
        issue(64'h5000, 32'h0000_2073, 1'b0, ill, flt, we, ok);
        chk("csrrs_ok", 64'(ok), 1);
        chk("csrrs_illegal", 64'(ill), 0);
        issue(64'h5004, 32'h0000_4073, 1'b0, ill, flt, we, ok);
        chk("sys100_ok", 64'(ok), 1);
        chk("sys100_illegal", 64'(ill), 1);
        issue(64'h5008, 32'h0000_200f, 1'b0, ill, flt, we, ok);
        chk("fence_var_illegal", 64'(ill), 1);
        issue(64'h500c, 32'h0000_100f, 1'b0, ill, flt, we, ok);
        chk("fencei_illegal", 64'(ill), 0);
        issue(64'h5010, 32'h0000_2083, 1'b0, ill, flt, we, ok);
        chk("lw_rd_we", 64'(we), 1);
        issue(64'h5014, 32'h0000_70b3 & 32'h0000_00a3 | 32'h0000_4023, 1'b0, ill, flt, we, ok);
        chk("sb_f3_100_illegal", 64'(ill), 1);
        rs1_valid = 1'b0; rs2_valid = 1'b0;
        issue(64'h5018, 32'h0000_0000, 1'b1, ill, flt, we, ok);
        rs1_valid = 1'b1; rs2_valid = 1'b1;
        chk("ifault_no_hazard", 64'(ok), 1);
        chk("ifault_flag", 64'(flt), 1);
        chk("ifault_illegal", 64'(ill), 0);
        chk("ifault_rd_we", 64'(we), 0);

        // Pointer wrap: 4*DEPTH instructions with random back-pressure
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 400 && recv < 4 * DEPTH; cyc++) begin
            out_block = ($urandom_range(0, 2) == 0);
            in_valid  = (sent < 4 * DEPTH);
            in_pc     = 64'h4000 + 64'(4 * sent);
            in_instr  = {12'(sent), 20'h00093};
            #1;
            chk("wrap_count_bound", 64'(count <= DEPTH), 1);
            if (out_valid && !out_block) begin
                chk("wrap_pc", out_pc, 64'h4000 + 64'(4 * recv));
                chk("wrap_instr", 64'(out_instr), 64'({12'(recv), 20'h00093}));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_block = 1'b0;
        chk("wrap_all_received", 64'(recv), 4 * DEPTH);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
